// File: rtl/control_pipe.sv
// Purpose: decodes 32-bit instructions into a registered control word, with a scoreboard interlock on in-flight writes.
// Latency: an instruction accepted in cycle N presents its control word in cycle N+1; one instruction per cycle with no hazards.
// Backpressure: instrReady drops on a read-after-write hazard or while a held word is not taken (ctrlReady low).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   instrValid/instrReady       instruction handshake; instrReady is combinational on instruction
//   instruction[31:0]           opcode[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0]
//   ctrlValid/ctrlReady         control word handshake towards execute
//   controlSignal[CW_W-1:0]     {srcA, srcB, dest, aluSrc, aluOp[2:0], memWrite, wbSel, regWrite}
//   issuedCount[15:0]           handoffs, wraps
//   stallCount[15:0]            cycles with instrValid high and instrReady low, saturating
//   illegalCount[7:0]           accepted unrecognised instructions, saturating
module control_pipe #(
    parameter int REG_BITS   = 5,
    parameter int PIPE_DEPTH = 3,
    localparam int CW_W      = 3*REG_BITS + 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instrValid,
    input  logic [31:0]     instruction,
    output logic            instrReady,
    output logic            ctrlValid,
    input  logic            ctrlReady,
    output logic [CW_W-1:0] controlSignal,
    output logic [15:0]     issuedCount,
    output logic [15:0]     stallCount,
    output logic [7:0]      illegalCount
);

    localparam logic [5:0] OP_RTYPE = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b001011;
    localparam logic [5:0] OP_SW    = 6'b001100;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_BITS-1:0] rs, rt, rd;
    logic                unused_bits;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rs     = instruction[21 +: REG_BITS];
    assign rt     = instruction[16 +: REG_BITS];
    assign rd     = instruction[11 +: REG_BITS];
    // shamt and immediate bits carry no control information here
    assign unused_bits = ^instruction;

    // ALU funct lookup
    logic       alu_hit;
    logic [2:0] alu_code;

    always_comb begin
        alu_hit  = 1'b1;
        alu_code = 3'd0;
        case (funct)
            6'd32:   alu_code = 3'd0;
            6'd34:   alu_code = 3'd1;
            6'd36:   alu_code = 3'd2;
            6'd37:   alu_code = 3'd3;
            6'd44:   alu_code = 3'd4;
            6'd45:   alu_code = 3'd5;
            6'd46:   alu_code = 3'd6;
            default: alu_hit  = 1'b0;
        endcase
    end

    // Decode of the presented instruction
    logic [REG_BITS-1:0] d_src_a, d_src_b, d_dest;
    logic                d_alu_src, d_mem_write, d_wb_sel, d_reg_write, d_legal;
    logic [2:0]          d_alu_op;
    logic                rd_a_en, rd_b_en;
    logic [CW_W-1:0]     dec_word;

    always_comb begin
        d_src_a     = '0;
        d_src_b     = '0;
        d_dest      = '0;
        d_alu_src   = 1'b0;
        d_alu_op    = 3'd0;
        d_mem_write = 1'b0;
        d_wb_sel    = 1'b0;
        d_reg_write = 1'b0;
        d_legal     = 1'b0;
        rd_a_en     = 1'b0;
        rd_b_en     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (alu_hit) begin
                    d_src_a     = rs;
                    d_src_b     = rt;
                    d_dest      = rd;
                    d_alu_op    = alu_code;
                    d_reg_write = 1'b1;
                    d_legal     = 1'b1;
                    rd_a_en     = 1'b1;
                    rd_b_en     = 1'b1;
                end else if (funct == 6'd31) begin
                    d_legal = 1'b1;  // explicit NOP: all-zero word, reads nothing
                end
            end
            OP_LW: begin
                d_src_a     = rs;
                d_dest      = rt;
                d_alu_src   = 1'b1;
                d_wb_sel    = 1'b1;
                d_reg_write = 1'b1;
                d_legal     = 1'b1;
                rd_a_en     = 1'b1;
            end
            OP_SW: begin
                d_src_a     = rs;
                d_src_b     = rt;
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
                d_wb_sel    = 1'b1;
                d_legal     = 1'b1;
                rd_a_en     = 1'b1;
                rd_b_en     = 1'b1;
            end
            default: ;
        endcase
        // register 0 is hardwired, so a write to it is dropped and never tracked
        if (d_dest == '0) begin
            d_reg_write = 1'b0;
        end
        dec_word = {d_src_a, d_src_b, d_dest, d_alu_src, d_alu_op,
                    d_mem_write, d_wb_sel, d_reg_write};
    end

    // Pending writes: the held output word plus the post-handoff scoreboard
    logic [REG_BITS-1:0] out_dest;
    logic                out_reg_write;
    logic [PIPE_DEPTH-1:0] sb_vld;
    logic [REG_BITS-1:0]   sb_dest [PIPE_DEPTH];
    logic                  hit_a, hit_b, hazard;

    assign out_dest      = controlSignal[7 +: REG_BITS];
    assign out_reg_write = controlSignal[0];

    always_comb begin
        hit_a = ctrlValid && out_reg_write && (out_dest == rs);
        hit_b = ctrlValid && out_reg_write && (out_dest == rt);
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            hit_a = hit_a | (sb_vld[k] && (sb_dest[k] == rs));
            hit_b = hit_b | (sb_vld[k] && (sb_dest[k] == rt));
        end
        hazard = (rd_a_en && (rs != '0) && hit_a) ||
                 (rd_b_en && (rt != '0) && hit_b);
    end

    logic accept, handoff;

    assign instrReady = !hazard && (!ctrlValid || ctrlReady);
    assign accept     = instrValid && instrReady;
    assign handoff    = ctrlValid && ctrlReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrlValid     <= 1'b0;
            controlSignal <= '0;
            issuedCount   <= 16'd0;
            stallCount    <= 16'd0;
            illegalCount  <= 8'd0;
            sb_vld        <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sb_dest[k] <= '0;
            end
        end else begin
            // downstream never stalls after handoff, so pending writes age one slot per cycle
            sb_vld[0]  <= handoff && out_reg_write;
            sb_dest[0] <= out_dest;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sb_vld[k]  <= sb_vld[k-1];
                sb_dest[k] <= sb_dest[k-1];
            end

            if (accept) begin
                controlSignal <= dec_word;
                ctrlValid     <= 1'b1;
            end else if (handoff) begin
                ctrlValid <= 1'b0;
            end

            if (handoff) begin
                issuedCount <= issuedCount + 16'd1;
            end
            if (instrValid && !instrReady && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
            if (accept && !d_legal && (illegalCount != 8'hFF)) begin
                illegalCount <= illegalCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// Purpose: randomized and directed checks of control_pipe against a per-register busy-time reference model.
// Latency: expected words queue on acceptance and are matched when the DUT hands off.
// Backpressure: ctrlReady is driven low at random and in a directed hold sequence.
module tb_control_pipe;

    localparam int RB = 5;
    localparam int PD = 3;
    localparam int CW = 3*RB + 7;

    logic          clk;
    logic          rst_n;
    logic          instrValid;
    logic [31:0]   instruction;
    logic          instrReady;
    logic          ctrlValid;
    logic          ctrlReady;
    logic [CW-1:0] controlSignal;
    logic [15:0]   issuedCount;
    logic [15:0]   stallCount;
    logic [7:0]    illegalCount;

    control_pipe #(.REG_BITS(RB), .PIPE_DEPTH(PD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instrValid   (instrValid),
        .instruction  (instruction),
        .instrReady   (instrReady),
        .ctrlValid    (ctrlValid),
        .ctrlReady    (ctrlReady),
        .controlSignal(controlSignal),
        .issuedCount  (issuedCount),
        .stallCount   (stallCount),
        .illegalCount (illegalCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [CW-1:0] cw;
        int            ra;     // read registers, 0 = none
        int            rb;
        int            wd;     // register written, 0 = none
        bit            legal;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t r;
        int op, fn, rs, rt, rd, mask;
        int sa, sb, de, asrc, aop, mw, wb, rw;
        int fn_list[7] = '{32, 34, 36, 37, 44, 45, 46};
        longint w;
        mask = (1 << RB) - 1;
        op = int'(ins >> 26);
        fn = int'(ins & 32'h3F);
        rs = int'(ins >> 21) & mask;
        rt = int'(ins >> 16) & mask;
        rd = int'(ins >> 11) & mask;
        sa = 0; sb = 0; de = 0; asrc = 0; aop = 0; mw = 0; wb = 0; rw = 0;
        r.ra = 0; r.rb = 0; r.legal = 0;
        if (op == 10) begin
            for (int i = 0; i < 7; i++) begin
                if (fn == fn_list[i]) begin
                    sa = rs; sb = rt; de = rd; aop = i; rw = 1;
                    r.ra = rs; r.rb = rt; r.legal = 1;
                end
            end
            if (fn == 31) r.legal = 1;
        end else if (op == 11) begin
            sa = rs; de = rt; asrc = 1; wb = 1; rw = 1;
            r.ra = rs; r.legal = 1;
        end else if (op == 12) begin
            sa = rs; sb = rt; asrc = 1; mw = 1; wb = 1;
            r.ra = rs; r.rb = rt; r.legal = 1;
        end
        if (de == 0) rw = 0;
        w = sa;
        w = w * (1 << RB) + sb;
        w = w * (1 << RB) + de;
        w = w * 2 + asrc;
        w = w * 8 + aop;
        w = w * 2 + mw;
        w = w * 2 + wb;
        w = w * 2 + rw;
        r.cw = CW'(w);
        r.wd = rw ? de : 0;
        return r;
    endfunction

    bit            m_vld;
    int            m_dest;
    int            last_ho [32];
    int            m_issued, m_stall, m_illegal;
    int            cyc = 0;
    logic [CW-1:0] exp_q [$];

    task automatic model_reset();
        m_vld = 0; m_dest = 0;
        m_issued = 0; m_stall = 0; m_illegal = 0;
        for (int i = 0; i < 32; i++) last_ho[i] = -1000;
        exp_q.delete();
    endtask

    // A register is busy while its writer sits in the output register, and
    // for PD cycles after the cycle in which that writer was handed off.
    function automatic bit busy(input int r, input int c);
        if (r == 0) return 0;
        return (m_vld && m_dest == r) || (c <= last_ho[r] + PD);
    endfunction

    // One clock cycle: drive, check readiness against the model at negedge, advance.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] ins, input bit cr,
                         output bit rdy);
        dec_t d;
        bit   mrdy, ho, acc;
        rst_n       = !rst;
        instrValid  = v;
        instruction = ins;
        ctrlReady   = cr;
        @(negedge clk);
        rdy = instrReady;
        if (!rst) begin
            d    = ref_decode(ins);
            mrdy = !(busy(d.ra, cyc) || busy(d.rb, cyc)) && (!m_vld || cr);
            check("instrReady", 32'(instrReady), 32'(mrdy));
            check("ctrlValid", 32'(ctrlValid), 32'(m_vld));
            ho  = m_vld && cr;
            acc = v && mrdy;
            if (ho) begin
                m_issued = (m_issued + 1) & 16'hFFFF;
                if (m_dest != 0) last_ho[m_dest] = cyc;
            end
            if (v && !mrdy && m_stall < 65535) m_stall++;
            if (acc) begin
                exp_q.push_back(d.cw);
                if (!d.legal && m_illegal < 255) m_illegal++;
                m_vld  = 1;
                m_dest = d.wd;
            end else if (ho) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        cyc++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [CW-1:0] e;
        if (rst_n === 1'b1 && ctrlValid === 1'b1 && ctrlReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL handoff_unexpected: got 0x%0h, required no handoff", controlSignal);
            end else begin
                e = exp_q.pop_front();
                check("controlSignal", 32'(controlSignal), 32'(e));
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int fn);
        return {6'b001010, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] lw_i(input int rs, input int rt);
        return {6'b001011, 5'(rs), 5'(rt), 16'h0010};
    endfunction
    function automatic logic [31:0] sw_i(input int rs, input int rt);
        return {6'b001100, 5'(rs), 5'(rt), 16'h0020};
    endfunction

    function automatic logic [31:0] rand_instr();
        int fns[9] = '{32, 34, 36, 37, 44, 45, 46, 31, 33};
        int k;
        logic [31:0] w;
        k = int'($urandom_range(0, 9));
        if (k <= 4) begin
            w = r_i(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), fns[$urandom_range(0, 8)]);
            w[10:6] = 5'($urandom);
        end else if (k <= 6) begin
            w = lw_i(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end else if (k == 7) begin
            w = sw_i(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end else if (k == 8) begin
            w = $urandom;
            w[31:26] = 6'($urandom_range(13, 63));
        end else begin
            w = $urandom;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bit   r;
        int   acc_at;
        logic [CW-1:0] held;

        rst_n = 1'b0; instrValid = 1'b0; instruction = '0; ctrlReady = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // reset state
        cycle(1, 0, 32'h0, 0, r);
        check("rst_ctrlValid", 32'(ctrlValid), 32'd0);
        check("rst_controlSignal", 32'(controlSignal), 32'd0);
        check("rst_issued", 32'(issuedCount), 32'd0);
        check("rst_stall", 32'(stallCount), 32'd0);
        check("rst_illegal", 32'(illegalCount), 32'd0);
        instruction = r_i(3, 3, 4, 32);
        #1;
        check("rst_instrReady", 32'(instrReady), 32'd1);

        // add r3 = r1 + r2
        cycle(0, 1, r_i(1, 2, 3, 32), 1, r);
        check("add_word", 32'(controlSignal),
              32'({5'd1, 5'd2, 5'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1}));
        cycle(0, 0, 32'h0, 1, r);
        check("add_issued", 32'(issuedCount), 32'd1);

        // dependent pair: consumer accepted PD+2 cycles after the producer
        cycle(1, 0, 32'h0, 0, r);
        cycle(0, 1, r_i(1, 2, 3, 32), 1, r);
        acc_at = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 1, r_i(3, 1, 4, 34), 1, r);
            if (r) begin
                acc_at = i;
                break;
            end
        end
        check("dep_accept_cycle", 32'(acc_at), 32'(PD + 2));
        check("dep_stall", 32'(stallCount), 32'(PD + 1));

        // LW then SW back to back
        cycle(1, 0, 32'h0, 0, r);
        cycle(0, 1, lw_i(1, 5), 1, r);
        check("lw_word", 32'(controlSignal),
              32'({5'd1, 5'd0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1}));
        cycle(0, 1, sw_i(2, 7), 1, r);
        check("sw_accepted", 32'(r), 32'd1);
        check("sw_word", 32'(controlSignal),
              32'({5'd2, 5'd7, 5'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0}));
        cycle(0, 0, 32'h0, 1, r);
        check("lwsw_stall", 32'(stallCount), 32'd0);

        // illegal encodings and writes to r0
        cycle(1, 0, 32'h0, 0, r);
        cycle(0, 1, 32'hFC00_0000, 1, r);
        check("illegal_op_word", 32'(controlSignal), 32'd0);
        cycle(0, 1, r_i(1, 2, 3, 33), 1, r);
        check("illegal_fn_word", 32'(controlSignal), 32'd0);
        cycle(0, 1, r_i(1, 2, 0, 32), 1, r);
        check("r0_regwrite", 32'(controlSignal[0]), 32'd0);
        cycle(0, 1, r_i(0, 0, 6, 32), 1, r);
        check("r0_reader_ready", 32'(r), 32'd1);
        cycle(0, 0, 32'h0, 1, r);
        check("illegal_count", 32'(illegalCount), 32'd2);

        // back-pressure hold for five cycles, then handoff and accept together
        cycle(1, 0, 32'h0, 0, r);
        cycle(0, 1, r_i(1, 2, 3, 32), 1, r);
        held = controlSignal;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, r_i(9, 10, 8, 37), 0, r);
            check("bp_ready_low", 32'(r), 32'd0);
            check("bp_word_stable", 32'(controlSignal), 32'(held));
        end
        check("bp_stall", 32'(stallCount), 32'd5);
        cycle(0, 1, r_i(9, 10, 8, 37), 1, r);
        check("bp_release_ready", 32'(r), 32'd1);
        check("bp_new_word", 32'(controlSignal),
              32'({5'd9, 5'd10, 5'd8, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1}));
        check("bp_valid_kept", 32'(ctrlValid), 32'd1);
        check("bp_issued", 32'(issuedCount), 32'd1);
        cycle(0, 0, 32'h0, 1, r);

        // reset in the middle of a hazard stall
        cycle(1, 0, 32'h0, 0, r);
        cycle(0, 1, r_i(1, 2, 3, 32), 1, r);
        cycle(0, 1, r_i(3, 3, 4, 36), 1, r);
        cycle(0, 1, r_i(3, 3, 4, 36), 1, r);
        cycle(1, 1, r_i(3, 3, 4, 36), 1, r);
        check("rst_mid_valid", 32'(ctrlValid), 32'd0);
        check("rst_mid_issued", 32'(issuedCount), 32'd0);
        check("rst_mid_stall", 32'(stallCount), 32'd0);
        cycle(0, 1, r_i(3, 3, 4, 36), 1, r);
        check("rst_mid_accept", 32'(r), 32'd1);

        // randomized traffic
        cycle(1, 0, 32'h0, 0, r);
        for (int i = 0; i < 3000; i++) begin
            cycle(0, ($urandom_range(0, 3) != 0), rand_instr(),
                  ($urandom_range(0, 3) != 0), r);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1, r);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_issued", 32'(issuedCount), 32'(m_issued));
        check("rand_stall", 32'(stallCount), 32'(m_stall));
        check("rand_illegal", 32'(illegalCount), 32'(m_illegal));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Parametrised, pipelined successor to the combinational instruction decoder. Accepts 32-bit instructions over a valid/ready handshake, decodes them into a registered control word for the execute/memory/write-back stages, and holds instructions that read a register still being written by an in-flight instruction (scoreboard interlock; no forwarding). Keeps issue, stall and illegal-opcode counters for debug.

## Interface
- REG_BITS, 5: register index width (1..5); index fields are the low REG_BITS bits of the instruction fields.
- PIPE_DEPTH, 3: cycles a handed-off write stays pending in the scoreboard (1..8).
- CW_W, 3*REG_BITS+7: control word width (derived, do not override).

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- instrValid  in  1  instruction present
- instruction  in  32  instruction word
- instrReady  out  1  instruction accepted this cycle when instrValid high
- ctrlValid  out  1  controlSignal holds a decoded instruction
- ctrlReady  in  1  downstream takes controlSignal this cycle
- controlSignal  out  CW_W  {srcA, srcB, dest, aluSrc, aluOp[2:0], memWrite, wbSel, regWrite}, MSB first
- issuedCount  out  16  handoffs, wraps
- stallCount  out  16  cycles with instrValid high and instrReady low, saturates at 0xFFFF
- illegalCount  out  8  accepted unrecognised instructions, saturates at 0xFF

## Operation
- Decode (opcode = instruction[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]):
  - 001010, funct 32/34/36/37/44/45/46 = add/sub/and/or/mul/div/xor: srcA=rs, srcB=rt, dest=rd, aluOp=0/1/2/3/4/5/6, aluSrc=0, memWrite=0, wbSel=0, regWrite=1.
  - 001010, funct 31: NOP, all fields zero; counts as legal.
  - 001011 LW: srcA=rs, srcB=0, dest=rt, aluSrc=1, aluOp=0, memWrite=0, wbSel=1, regWrite=1.
  - 001100 SW: srcA=rs, srcB=rt, dest=0, aluSrc=1, aluOp=0, memWrite=1, wbSel=1, regWrite=0.
  - Anything else (other opcode, or 001010 with other funct): NOP word, illegalCount += 1 on acceptance.
  - regWrite with dest==0 is forced to regWrite=0 (register 0 never written).
- Read set: R-type reads rs, rt; LW reads rs; SW reads rs, rt; NOP/illegal read nothing. Index 0 never hazards.
- Pending set: output register (when ctrlValid and regWrite) plus PIPE_DEPTH scoreboard slots {valid, dest}.
- hazard = any read index equals any pending dest.
- instrReady = !hazard && (!ctrlValid || ctrlReady); hazard uses the current instruction, so instrReady is combinational on instruction.
- Accept (instrValid && instrReady): decoded word loads controlSignal, ctrlValid=1.
- Handoff (ctrlValid && ctrlReady): issuedCount += 1; if no new accept, ctrlValid=0.
- Scoreboard shifts every cycle: slot0 <= {handoff && regWrite, dest}, slot k <= slot k-1, slot PIPE_DEPTH-1 falls off. Downstream is non-stalling after handoff.

## Timing
- Reset (rst_n low at edge): ctrlValid=0, controlSignal=0, all scoreboard slots invalid, all counters 0; instrReady evaluates to 1 for any instruction after reset. Reset mid-stall drops the held instruction and all pending state.
- Latency: accepted at cycle N -> ctrlValid with its word at N+1.
- Throughput: 1/cycle with ctrlReady high and no hazards.
- Back-pressure: ctrlReady low holds controlSignal and ctrlValid stable; instrReady low.
- Simultaneous handoff + accept: new word replaces old, ctrlValid stays 1, no bubble.
- Dependent pair, producer accepted at N, handoff at N+1: consumer stalled through N+PIPE_DEPTH+1, accepted at N+PIPE_DEPTH+2 (PIPE_DEPTH+1 bubbles).
- Counters: issuedCount wraps 0xFFFF->0; stallCount and illegalCount hold at max.

## Test plan
- Reset then add r3=r1+r2 (0x28221820... i.e. op 001010, rs1 rt2 rd3, funct 32), ctrlReady=1 -> next cycle ctrlValid=1, controlSignal fields {1,2,3,0,0,0,0,1}, issuedCount=1.
- PIPE_DEPTH=3: add rd=3 at cycle 0, then sub reading r3 held valid -> instrReady low cycles 1..4, accepted cycle 5, stallCount=4.
- LW r5<-[r1], then SW [r2]<-r7 back-to-back -> no stall; SW word {2,7,0,1,0,1,1,0}; LW word {1,0,5,1,0,0,1,1}.
- Opcode 111111 and 001010/funct 33 accepted -> NOP words, illegalCount=2; add with rd=0 -> regWrite=0, later reader of r0 never stalls.
- ctrlReady low for 5 cycles with instrValid high -> controlSignal stable, instrReady=0, stallCount=5; ctrlReady high -> handoff and accept in same cycle.
- rst_n low during a hazard stall -> next cycle ctrlValid=0, counters 0, previously blocked instruction accepted immediately.
